// File: rtl/alu_ctrl_decode_stage.sv
// Registered ALU control decoder at the ID/EX boundary: one-entry valid/ready
// stage that decodes the opcode, and holds the stage for multi-cycle MUL ops.
module alu_ctrl_decode_stage #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [10:0]       opcode,
  input  logic              alu_on,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_cntrl,
  output logic              set_flags,
  output logic              illegal,
  output logic              mc_busy
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  localparam logic [CTRL_W-1:0] C_PASSB = CTRL_W'(4'h0);
  localparam logic [CTRL_W-1:0] C_ADD   = CTRL_W'(4'h2);
  localparam logic [CTRL_W-1:0] C_SUB   = CTRL_W'(4'h3);
  localparam logic [CTRL_W-1:0] C_ZTEST = CTRL_W'(4'h4);
  localparam logic [CTRL_W-1:0] C_AND   = CTRL_W'(4'h5);
  localparam logic [CTRL_W-1:0] C_ORR   = CTRL_W'(4'h6);
  localparam logic [CTRL_W-1:0] C_EOR   = CTRL_W'(4'h7);
  localparam logic [CTRL_W-1:0] C_LSL   = CTRL_W'(4'h8);
  localparam logic [CTRL_W-1:0] C_LSR   = CTRL_W'(4'h9);
  localparam logic [CTRL_W-1:0] C_MUL   = CTRL_W'(4'hA);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_MC_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] code;
    logic              set_flags;
    logic              illegal;
    logic              is_mul;
  } dec_t;

  // First-match decode; anything unmatched yields code 0 with illegal set.
  function automatic dec_t decode(input logic [10:0] op, input logic on);
    dec_t d;
    d = '{code: C_PASSB, set_flags: 1'b0, illegal: 1'b0, is_mul: 1'b0};
    if (on) begin
      casez (op)
        11'b10001011000: d.code = C_ADD;
        11'b10101011000: begin d.code = C_ADD; d.set_flags = 1'b1; end
        11'b1001000100?: d.code = C_ADD;
        11'b11111000010: d.code = C_ADD;
        11'b11111000000: d.code = C_ADD;
        11'b11001011000: d.code = C_SUB;
        11'b11101011000: begin d.code = C_SUB; d.set_flags = 1'b1; end
        11'b100101?????: d.code = C_PASSB;
        11'b10110100???: d.code = C_ZTEST;
        11'b10001010000: d.code = C_AND;
        11'b10101010000: d.code = C_ORR;
        11'b11001010000: d.code = C_EOR;
        11'b11010011011: d.code = C_LSL;
        11'b11010011010: d.code = C_LSR;
        11'b10011011000: begin d.code = C_MUL; d.is_mul = 1'b1; end
        default:         d.illegal = 1'b1;
      endcase
    end else begin
      d.illegal = 1'b0;
    end
    return d;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              load_s;
  logic              accept_s;
  dec_t              dec_s;

  assign dec_s     = decode(opcode, alu_on);
  assign in_ready  = !flush && ((state_r == ST_EMPTY) ||
                                ((state_r == ST_FULL) && out_ready));
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_r == ST_FULL);
  assign mc_busy   = (state_r == ST_MC_WAIT);

  // Next-state, MUL countdown and output-register load enable.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    load_s      = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        ST_EMPTY, ST_FULL: begin
          if (accept_s) begin
            load_s = 1'b1;
            if (dec_s.is_mul && (MUL_LAT > 1)) begin
              state_nxt_s = ST_MC_WAIT;
              cnt_nxt_s   = CNT_W'(MUL_LAT - 1);
            end else begin
              state_nxt_s = ST_FULL;
            end
          end else if ((state_r == ST_FULL) && out_ready) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_MC_WAIT: begin
          if (cnt_r == CNT_W'(1)) begin
            state_nxt_s = ST_FULL;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s   = cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // State, counter and output registers; reset wins over flush.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= ST_EMPTY;
      cnt_r     <= '0;
      alu_cntrl <= '0;
      set_flags <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (load_s) begin
        alu_cntrl <= dec_s.code;
        set_flags <= dec_s.set_flags;
        illegal   <= dec_s.illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Scoreboard bench for alu_ctrl_decode_stage: one instance with MUL_LAT=3, one with MUL_LAT=1.
module tb_alu_ctrl_decode_stage;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_ADDI = 11'b10010001001;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_BL   = 11'b10010111010;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_MUL  = 11'b10011011000;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, flush, in_valid, in_ready, alu_on, out_valid, out_ready;
  logic        set_flags, illegal, mc_busy;
  logic [10:0] opcode;
  logic [3:0]  alu_cntrl;

  logic        b_flush, b_in_valid, b_in_ready, b_alu_on, b_out_valid, b_out_ready;
  logic        b_set_flags, b_illegal, b_mc_busy;
  logic [10:0] b_opcode;
  logic [3:0]  b_alu_cntrl;

  alu_ctrl_decode_stage #(.CTRL_W(4), .MUL_LAT(3)) u3 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .opcode(opcode), .alu_on(alu_on), .out_valid(out_valid),
    .out_ready(out_ready), .alu_cntrl(alu_cntrl), .set_flags(set_flags),
    .illegal(illegal), .mc_busy(mc_busy));

  alu_ctrl_decode_stage #(.CTRL_W(4), .MUL_LAT(1)) u1 (
    .clk(clk), .reset_n(reset_n), .flush(b_flush), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .opcode(b_opcode), .alu_on(b_alu_on), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .alu_cntrl(b_alu_cntrl), .set_flags(b_set_flags),
    .illegal(b_illegal), .mc_busy(b_mc_busy));

  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q[$];
  logic [5:0] exp_b_q[$];

  function automatic logic [5:0] mk(input logic [3:0] code, input logic sf, input logic ill);
    return {code, sf, ill};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitors: compare every consumed output against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL u3_unexpected_out actual=0x%0h required=none", {alu_cntrl, set_flags, illegal});
      end else begin
        chk("u3_sb_out", {alu_cntrl, set_flags, illegal}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && b_out_valid && b_out_ready) begin
      if (exp_b_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL u1_unexpected_out actual=0x%0h required=none", {b_alu_cntrl, b_set_flags, b_illegal});
      end else begin
        chk("u1_sb_out", {b_alu_cntrl, b_set_flags, b_illegal}, exp_b_q.pop_front());
      end
    end
  end

  // Present one op until accepted (bounded), queue its expectation, then deassert.
  task automatic issue(input logic [10:0] op, input logic on, input logic [5:0] e);
    int n;
    n = 0;
    in_valid = 1'b1; opcode = op; alu_on = on;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("issue_timeout", {31'd0, in_ready}, 32'd1);
    else exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [10:0] tp_op[3];
  logic [5:0]  tp_e[3];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; opcode = 11'd0; alu_on = 1'b0;
    out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b0; b_opcode = 11'd0; b_alu_on = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outputs", {alu_cntrl, set_flags, illegal, mc_busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Throughput: three back-to-back ops with EX always ready.
    tp_op[0] = OP_ADDS; tp_e[0] = mk(4'h2, 1'b1, 1'b0);
    tp_op[1] = OP_SUBS; tp_e[1] = mk(4'h3, 1'b1, 1'b0);
    tp_op[2] = OP_CBZ;  tp_e[2] = mk(4'h4, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; opcode = tp_op[i]; alu_on = 1'b1;
      @(negedge clk);
      chk("tp_in_ready", {31'd0, in_ready}, 32'd1);
      if (i > 0) chk("tp_cycle_out", {out_valid, alu_cntrl, set_flags}, {26'd0, 1'b1, tp_e[i-1][5:1]});
      exp_q.push_back(tp_e[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("tp_cycle_out", {out_valid, alu_cntrl, set_flags}, {26'd0, 1'b1, tp_e[2][5:1]});
    @(posedge clk); #1;

    // Backpressure: LDUR held while EX stalls, then AND follows on release.
    out_ready = 1'b0;
    issue(OP_LDUR, 1'b1, mk(4'h2, 1'b0, 1'b0));
    in_valid = 1'b1; opcode = OP_AND; alu_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, alu_cntrl, in_ready}, {26'd0, 1'b1, 4'h2, 1'b0});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(mk(4'h5, 1'b0, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_op", {out_valid, alu_cntrl}, {27'd0, 1'b1, 4'h5});
    @(posedge clk); #1;

    // MUL with MUL_LAT=3: busy for two cycles, result after the third edge.
    in_valid = 1'b1; opcode = OP_MUL; alu_on = 1'b1;
    @(negedge clk);
    chk("mul_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(mk(4'hA, 1'b0, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mul_wait", {mc_busy, out_valid, in_ready}, {29'd0, 3'b100});
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("mul_done", {mc_busy, out_valid, alu_cntrl}, {26'd0, 1'b0, 1'b1, 4'hA});
    @(posedge clk); #1;

    // Decode table including illegal, bubble and a stalling MUL.
    issue(OP_BAD,  1'b1, mk(4'h0, 1'b0, 1'b1));
    issue(OP_ADD,  1'b0, mk(4'h0, 1'b0, 1'b0));
    issue(OP_BAD,  1'b0, mk(4'h0, 1'b0, 1'b0));
    issue(OP_ADD,  1'b1, mk(4'h2, 1'b0, 1'b0));
    issue(OP_ADDI, 1'b1, mk(4'h2, 1'b0, 1'b0));
    issue(11'b10010001000, 1'b1, mk(4'h2, 1'b0, 1'b0));
    issue(OP_STUR, 1'b1, mk(4'h2, 1'b0, 1'b0));
    issue(OP_SUB,  1'b1, mk(4'h3, 1'b0, 1'b0));
    issue(OP_BL,   1'b1, mk(4'h0, 1'b0, 1'b0));
    issue(OP_ORR,  1'b1, mk(4'h6, 1'b0, 1'b0));
    issue(OP_MUL,  1'b1, mk(4'hA, 1'b0, 1'b0));
    issue(OP_EOR,  1'b1, mk(4'h7, 1'b0, 1'b0));
    issue(OP_LSL,  1'b1, mk(4'h8, 1'b0, 1'b0));
    issue(OP_LSR,  1'b1, mk(4'h9, 1'b0, 1'b0));
    issue(11'b10001011001, 1'b1, mk(4'h0, 1'b0, 1'b1));
    repeat (2) @(posedge clk);
    #1;

    // Flush while FULL under backpressure: entry dropped, SUB not taken.
    out_ready = 1'b0;
    issue(OP_ADD, 1'b1, mk(4'h2, 1'b0, 1'b0));
    flush = 1'b1; in_valid = 1'b1; opcode = OP_SUB; alu_on = 1'b1;
    @(negedge clk);
    chk("flush_full_in_ready", {31'd0, in_ready}, 32'd0);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("flush_full_out", {out_valid, mc_busy}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;

    // Flush in MC_WAIT aborts the MUL.
    issue(OP_MUL, 1'b1, mk(4'hA, 1'b0, 1'b0));
    flush = 1'b1; in_valid = 1'b1; opcode = OP_ADD; alu_on = 1'b1;
    @(negedge clk);
    chk("flush_mc_state", {in_ready, mc_busy}, {30'd0, 2'b01});
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_mc_out", {out_valid, mc_busy}, 32'd0);
      @(posedge clk); #1;
    end

    // Reset in the middle of a MUL clears everything.
    issue(OP_MUL, 1'b1, mk(4'hA, 1'b0, 1'b0));
    reset_n = 1'b0;
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midmul_rst_outputs", {out_valid, alu_cntrl, set_flags, illegal, mc_busy}, 32'd0);
    chk("midmul_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midmul_rst_stays_empty", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // MUL_LAT=1 instance: MUL behaves like a single-cycle op.
    b_in_valid = 1'b1; b_opcode = OP_MUL; b_alu_on = 1'b1;
    @(negedge clk);
    chk("u1_mul_in_ready", {31'd0, b_in_ready}, 32'd1);
    exp_b_q.push_back(mk(4'hA, 1'b0, 1'b0));
    @(posedge clk); #1;
    b_opcode = OP_ADDS;
    @(negedge clk);
    chk("u1_mul_out", {b_out_valid, b_mc_busy, b_alu_cntrl, b_in_ready}, {25'd0, 1'b1, 1'b0, 4'hA, 1'b1});
    exp_b_q.push_back(mk(4'h2, 1'b1, 1'b0));
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("u1_adds_out", {b_out_valid, b_alu_cntrl, b_set_flags}, {26'd0, 1'b1, 4'h2, 1'b1});
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk("u3_sb_drained", exp_q.size(), 32'd0);
    chk("u1_sb_drained", exp_b_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
